// File: rtl/fwd_pkg.sv
// Shared constants for the EX-stage forwarding unit: register-file geometry and
// the fwd_sel source encoding.
package fwd_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int FWD_RF       = 0;
  localparam int FWD_STG_BASE = 1;

  // One code per stage, plus register file and completion bus.
  function automatic int sel_w(input int fwd_stages);
    return $clog2(fwd_stages + 2);
  endfunction
endpackage

// File: rtl/fwd_src_sel.sv
// Resolves one EX source operand: youngest matching stage wins, then the
// completion bus, then the outstanding-write scoreboard.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = 2
) (
  input  logic [REG_ADDR_W-1:0]            i_src_addr,
  input  logic                             i_src_used,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] i_stg_rd,
  input  logic [FWD_STAGES-1:0]            i_stg_regwrite,
  input  logic [FWD_STAGES-1:0]            i_stg_data_ready,
  input  logic                             i_complete_valid,
  input  logic [REG_ADDR_W-1:0]            i_complete_rd,
  input  logic [NUM_REGS-1:0]              i_pend,
  output logic [SEL_W-1:0]                 o_sel,
  output logic                             o_hazard
);

  logic w_hit;

  always_comb begin
    o_sel    = SEL_W'(FWD_RF);
    o_hazard = 1'b0;
    w_hit    = 1'b0;
    if (i_src_used && i_src_addr != '0) begin
      // A stage hit masks every older stage and the scoreboard, even when its data is late.
      for (int k = 0; k < FWD_STAGES; k++) begin
        if (!w_hit && i_stg_regwrite[k] && i_stg_rd[k*REG_ADDR_W +: REG_ADDR_W] == i_src_addr) begin
          w_hit = 1'b1;
          if (i_stg_data_ready[k]) o_sel = SEL_W'(k + FWD_STG_BASE);
          else                     o_hazard = 1'b1;
        end
      end
      if (!w_hit) begin
        if (i_complete_valid && i_complete_rd == i_src_addr) o_sel = SEL_W'(FWD_STAGES + 1);
        else if (i_pend[i_src_addr])                         o_hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// EX operand forwarding and hazard unit with a per-register scoreboard of
// outstanding long-latency writes, plus stall statistics and sticky error flags.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int PEND_W     = 2,
  parameter int HANG_LIMIT = 1024,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = sel_w(FWD_STAGES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_addr,
  input  logic [NUM_SRC-1:0]               src_used,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] stg_rd,
  input  logic [FWD_STAGES-1:0]            stg_regwrite,
  input  logic [FWD_STAGES-1:0]            stg_data_ready,
  input  logic                             issue_valid,
  input  logic [REG_ADDR_W-1:0]            issue_rd,
  input  logic                             flush,
  input  logic                             complete_valid,
  input  logic [REG_ADDR_W-1:0]            complete_rd,
  output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
  output logic                             stall,
  output logic [NUM_REGS-1:0]              pending_vec,
  output logic [CNT_W-1:0]                 stall_cnt,
  output logic                             sb_err,
  output logic                             hang_err
);

  localparam int RUN_W = $clog2(HANG_LIMIT + 1);

  logic [PEND_W-1:0]   r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_pend;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [NUM_SRC-1:0]  w_hazard;
  logic                w_iss;
  logic                w_cmp;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [RUN_W-1:0]    r_run;
  logic                r_sb_err;
  logic                r_hang_err;

  // issue/complete are single-cycle strobes with no back-pressure; r0 is never tracked.
  assign w_iss = issue_valid && !flush && issue_rd != '0;
  assign w_cmp = complete_valid && complete_rd != '0;

  always_comb begin
    w_pend = '0;
    w_inc  = '0;
    w_dec  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_pend[r] = (r_cnt[r] != '0);
      w_inc[r]  = w_iss && issue_rd == REG_ADDR_W'(r);
      w_dec[r]  = w_cmp && complete_rd == REG_ADDR_W'(r);
    end
  end

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_src_sel #(.FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_src_sel (
      .i_src_addr      (src_addr[j*REG_ADDR_W +: REG_ADDR_W]),
      .i_src_used      (src_used[j]),
      .i_stg_rd        (stg_rd),
      .i_stg_regwrite  (stg_regwrite),
      .i_stg_data_ready(stg_data_ready),
      .i_complete_valid(complete_valid),
      .i_complete_rd   (complete_rd),
      .i_pend          (w_pend),
      .o_sel           (fwd_sel[j*SEL_W +: SEL_W]),
      .o_hazard        (w_hazard[j])
    );
  end

  assign stall = |w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_sb_err <= 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        // Simultaneous issue and complete to one register cancel out.
        if (w_inc[r] && !w_dec[r]) begin
          if (r_cnt[r] == '1) r_sb_err <= 1'b1;
          else                r_cnt[r] <= r_cnt[r] + PEND_W'(1);
        end else if (w_dec[r] && !w_inc[r]) begin
          if (r_cnt[r] == '0) r_sb_err <= 1'b1;
          else                r_cnt[r] <= r_cnt[r] - PEND_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_run       <= '0;
      r_hang_err  <= 1'b0;
    end else begin
      if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!stall) begin
        r_run <= '0;
      end else begin
        if (r_run != RUN_W'(HANG_LIMIT))   r_run <= r_run + RUN_W'(1);
        if (r_run == RUN_W'(HANG_LIMIT - 1)) r_hang_err <= 1'b1;
      end
    end
  end

  assign pending_vec = w_pend;
  assign stall_cnt   = r_stall_cnt;
  assign sb_err      = r_sb_err;
  assign hang_err    = r_hang_err;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: directed scenarios plus random traffic, checked
// against a behavioural model through an expected-response queue.
module tb_fwd_scoreboard_unit;
  localparam int NS = 2;
  localparam int FS = 2;
  localparam int PW = 2;
  localparam int HL = 1024;
  localparam int CW = 32;
  localparam int SW = 2;
  localparam int W  = NS*SW + 1 + 32 + CW + 2;
  localparam int PMAX = (1 << PW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NS*5-1:0] src_addr = '0;
  logic [NS-1:0]   src_used = '0;
  logic [FS*5-1:0] stg_rd = '0;
  logic [FS-1:0]   stg_regwrite = '0;
  logic [FS-1:0]   stg_data_ready = '0;
  logic            issue_valid = 1'b0;
  logic [4:0]      issue_rd = '0;
  logic            flush = 1'b0;
  logic            complete_valid = 1'b0;
  logic [4:0]      complete_rd = '0;
  logic [NS*SW-1:0] fwd_sel;
  logic            stall;
  logic [31:0]     pending_vec;
  logic [CW-1:0]   stall_cnt;
  logic            sb_err;
  logic            hang_err;

  fwd_scoreboard_unit #(.NUM_SRC(NS), .FWD_STAGES(FS), .PEND_W(PW), .HANG_LIMIT(HL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src_addr(src_addr), .src_used(src_used), .stg_rd(stg_rd),
    .stg_regwrite(stg_regwrite), .stg_data_ready(stg_data_ready), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .complete_valid(complete_valid), .complete_rd(complete_rd),
    .fwd_sel(fwd_sel), .stall(stall), .pending_vec(pending_vec), .stall_cnt(stall_cnt),
    .sb_err(sb_err), .hang_err(hang_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  int          m_cnt [32];
  longint      m_scnt;
  int          m_run;
  bit          m_sb;
  bit          m_hang;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_scnt = 0; m_run = 0; m_sb = 0; m_hang = 0;
  endtask

  // Where does operand value come from, and must EX wait for it?
  function automatic void ref_op(input int a, input bit used, output int sel, output bit hz);
    sel = 0; hz = 0;
    if (!used || a == 0) return;
    for (int k = 0; k < FS; k++) begin
      if (stg_regwrite[k] && int'(stg_rd[k*5 +: 5]) == a) begin
        if (stg_data_ready[k]) sel = k + 1;
        else hz = 1;
        return;
      end
    end
    if (complete_valid && int'(complete_rd) == a) begin sel = FS + 1; return; end
    if (m_cnt[a] != 0) hz = 1;
  endfunction

  task automatic model_edge(input bit st);
    bit iss, cmp;
    iss = issue_valid && !flush && issue_rd != 0;
    cmp = complete_valid && complete_rd != 0;
    if (iss && !(cmp && complete_rd == issue_rd)) begin
      if (m_cnt[issue_rd] == PMAX) m_sb = 1; else m_cnt[issue_rd]++;
    end
    if (cmp && !(iss && complete_rd == issue_rd)) begin
      if (m_cnt[complete_rd] == 0) m_sb = 1; else m_cnt[complete_rd]--;
    end
    if (st && m_scnt < 64'hFFFF_FFFF) m_scnt++;
    m_run = st ? m_run + 1 : 0;
    if (m_run >= HL) m_hang = 1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input string nm);
    logic [NS*SW-1:0] sv;
    logic [31:0]      pv;
    bit               st, hz;
    int               s;
    if (rst) model_clear();
    sv = '0; st = 0;
    for (int j = 0; j < NS; j++) begin
      ref_op(int'(src_addr[j*5 +: 5]), src_used[j], s, hz);
      sv[j*SW +: SW] = SW'(s);
      st = st | hz;
    end
    for (int r = 0; r < 32; r++) pv[r] = (m_cnt[r] != 0);
    exp_q.push_back({sv, st, pv, CW'(m_scnt), m_sb, m_hang});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (!rst) model_edge(st);
    @(negedge clk);
  endtask

  task automatic idle();
    src_addr = '0; src_used = '0; stg_rd = '0; stg_regwrite = '0; stg_data_ready = '0;
    issue_valid = 0; issue_rd = '0; flush = 0; complete_valid = 0; complete_rd = '0;
  endtask

  task automatic do_issue(input int rd);
    idle(); issue_valid = 1; issue_rd = 5'(rd);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e, a;
    string        nm;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {fwd_sel, stall, pending_vec, stall_cnt, sb_err, hang_err};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got sel=%h stall=%b pend=%h scnt=%0d sb=%b hang=%b, expected sel=%h stall=%b pend=%h scnt=%0d sb=%b hang=%b",
                   nm, a[W-1 -: NS*SW], a[W-1-NS*SW], a[CW+33 -: 32], a[CW+1 -: CW], a[1], a[0],
                   e[W-1 -: NS*SW], e[W-1-NS*SW], e[CW+33 -: 32], e[CW+1 -: CW], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    @(negedge clk);
    idle(); rst = 1; step("reset_init");
    rst = 0;
    do_issue(5); step("issue_x5");
    do_issue(6); step("issue_x6");
    idle(); src_addr[4:0] = 5; src_used = 2'b01; step("pend_x5_stall");
    rst = 1; step("reset_mid_stall");
    rst = 0; idle(); step("after_reset");

    idle(); src_addr[4:0] = 3; src_used = 2'b01;
    stg_rd = {5'd3, 5'd3}; stg_regwrite = 2'b11; stg_data_ready = 2'b11; step("youngest_wins");
    idle(); src_addr[9:5] = 7; src_used = 2'b10;
    stg_rd[4:0] = 7; stg_regwrite = 2'b01; stg_data_ready = 2'b00; step("load_in_mem");
    stg_data_ready = 2'b01; step("load_ready");

    do_issue(9); step("issue_x9");
    idle(); src_addr[4:0] = 9; src_used = 2'b01; step("x9_pending");
    complete_valid = 1; complete_rd = 9; step("x9_complete_bus");
    idle(); step("x9_cleared");

    repeat (3) begin do_issue(4); step("issue_x4"); end
    idle(); step("x4_cnt3");
    do_issue(4); step("x4_overflow");
    idle(); step("x4_sb_err");

    idle(); src_addr = {5'd0, 5'd0}; src_used = 2'b11; stg_rd = '0; stg_regwrite = 2'b01;
    stg_data_ready = 2'b00; step("src_x0");
    idle(); issue_valid = 1; issue_rd = 8; flush = 1; step("flush_x8");
    idle(); step("x8_not_pending");

    rst = 1; idle(); step("reset_rand");
    rst = 0;
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < NS; j++) src_addr[j*5 +: 5] = 5'($urandom_range(0, 7));
      src_used       = 2'($urandom_range(0, 3));
      for (int k = 0; k < FS; k++) stg_rd[k*5 +: 5] = 5'($urandom_range(0, 7));
      stg_regwrite   = 2'($urandom_range(0, 3));
      stg_data_ready = 2'($urandom_range(0, 3));
      issue_valid    = ($urandom_range(0, 3) == 0);
      issue_rd       = 5'($urandom_range(0, 7));
      flush          = ($urandom_range(0, 7) == 0);
      complete_valid = ($urandom_range(0, 3) == 0);
      complete_rd    = 5'($urandom_range(0, 7));
      step("random");
    end

    rst = 1; idle(); step("reset_hang");
    rst = 0;
    do_issue(10); step("issue_x10");
    idle(); src_addr[4:0] = 10; src_used = 2'b01;
    repeat (HL) step("hang_hold");
    idle(); step("hang_set");
    step("hang_sticky");

    idle();
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
